// File: rtl/div_arbiter.sv
// Round-robin front end that shares one multi-cycle divider among NREQ requesters.
// Divide-by-zero is answered locally without starting the divider.
module div_arbiter #(
    parameter int SIZE      = 4,
    parameter int NREQ      = 4,
    parameter int START_CYC = 2,
    parameter int DIV_LAT   = 2*SIZE+7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*SIZE-1:0] req_a,
    input  logic [NREQ*SIZE-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [SIZE-1:0]      rsp_quotient,
    output logic [SIZE-1:0]      rsp_remainder,
    output logic                 rsp_dbz,
    output logic                 div_start,
    output logic [SIZE-1:0]      div_a,
    output logic [SIZE-1:0]      div_b,
    input  logic [SIZE-1:0]      div_quotient,
    input  logic [SIZE-1:0]      div_remainder
);

    localparam int CW = $clog2(DIV_LAT+1);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t          state, state_d;
    logic [IW-1:0]   rr_ptr, owner, grant_idx, next_ptr;
    logic [CW-1:0]   cnt;
    logic            grant_found, accept;
    logic [SIZE-1:0] sel_a, sel_b;

    // Search upward from rr_ptr with wrap-around; the first valid bit wins.
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        int j;
        grant_found = 1'b0;
        grant_idx   = '0;
        j           = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!grant_found && req_valid[j]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(j);
            end
        end
    end

    assign req_ready = (state == IDLE && rst_n && grant_found) ? (NREQ'(1) << grant_idx) : '0;
    assign accept    = |(req_valid & req_ready);
    assign sel_a     = req_a[int'(grant_idx)*SIZE +: SIZE];
    assign sel_b     = req_b[int'(grant_idx)*SIZE +: SIZE];
    assign next_ptr  = (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + IW'(1);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = (sel_b == '0) ? RESP : START;
            START:   if (cnt == CW'(START_CYC-1)) state_d = WAIT;
            WAIT:    if (cnt == CW'(DIV_LAT-1)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            owner         <= '0;
            cnt           <= '0;
            div_a         <= '0;
            div_b         <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    owner  <= grant_idx;
                    rr_ptr <= next_ptr;
                    div_a  <= sel_a;
                    div_b  <= sel_b;
                    cnt    <= '0;
                    if (sel_b == '0) begin
                        rsp_quotient  <= '1;
                        rsp_remainder <= sel_a;
                        rsp_dbz       <= 1'b1;
                    end
                end
                START, WAIT: begin
                    cnt <= cnt + CW'(1);
                    // Divider outputs are valid in the last WAIT cycle.
                    if (state == WAIT && cnt == CW'(DIV_LAT-1)) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_dbz       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_start = (state == START);
    assign rsp_valid = (state == RESP) ? (NREQ'(1) << owner) : '0;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a latency-accurate divider model that
// presents wrong values until the result is due.
module tb_div_arbiter;

    localparam int SIZE    = 4;
    localparam int NREQ    = 4;
    localparam int DIV_LAT = 15;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*SIZE-1:0] req_a = '0;
    logic [NREQ*SIZE-1:0] req_b = '0;
    logic [NREQ-1:0]      req_ready, rsp_valid;
    logic [SIZE-1:0]      rsp_quotient, rsp_remainder, div_a, div_b;
    logic [SIZE-1:0]      div_quotient, div_remainder;
    logic                 rsp_dbz, div_start;

    int errors = 0;
    int checks = 0;

    div_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .START_CYC(2), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_dbz(rsp_dbz), .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    // Divider model: operands captured on the first start cycle, correct
    // outputs from DIV_LAT-1 edges later, inverted values before that.
    logic [SIZE-1:0] ma, mb;
    logic            start_q;
    int              mc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '0; mb <= 4'd1; start_q <= 1'b0; mc <= 0;
        end else begin
            start_q <= div_start;
            if (div_start && !start_q) begin
                ma <= div_a; mb <= div_b; mc <= 1;
            end else if (mc < 1000) begin
                mc <= mc + 1;
            end
        end
    end

    assign div_quotient  = (mc >= DIV_LAT-1) ? ma / mb : ~(ma / mb);
    assign div_remainder = (mc >= DIV_LAT-1) ? ma % mb : ~(ma % mb);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        req_a[i*SIZE +: SIZE] = a;
        req_b[i*SIZE +: SIZE] = b;
    endtask

    // Called at a negedge with inputs driven; ends at the negedge after the accept edge.
    task automatic accept(input string tag, input logic [NREQ-1:0] exp_ready);
        #1;
        check({tag, "_ready"}, req_ready, exp_ready);
        @(negedge clk);
    endtask

    task automatic expect_rsp(input string tag, input logic [NREQ-1:0] exp_v,
                              input logic [SIZE-1:0] q, input logic [SIZE-1:0] r,
                              input logic dbz, input int exp_lat, input int exp_starts);
        int lat = 0;
        int starts = 0;
        while (rsp_valid === '0 && lat < 40) begin
            if (div_start) starts++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_starts"}, starts, exp_starts);
        check({tag, "_rspv"}, rsp_valid, exp_v);
        check({tag, "_q"}, rsp_quotient, q);
        check({tag, "_r"}, rsp_remainder, r);
        check({tag, "_dbz"}, rsp_dbz, dbz);
        @(negedge clk);
        check({tag, "_rspv_off"}, rsp_valid, 0);
    endtask

    logic [SIZE-1:0] ta [4] = '{4'd15, 4'd13, 4'd9, 4'd6};
    logic [SIZE-1:0] tb [4] = '{4'd2,  4'd3,  4'd4, 4'd7};
    logic [SIZE-1:0] tq [4] = '{4'd7,  4'd4,  4'd2, 4'd0};
    logic [SIZE-1:0] tr [4] = '{4'd1,  4'd1,  4'd1, 4'd6};

    initial begin
        int quiet;

        // Reset: ready gated even with requests present.
        repeat (2) @(negedge clk);
        req_valid = 4'hF;
        #1;
        check("rst_ready", req_ready, 0);
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rspv", rsp_valid, 0);
        check("rst_start", div_start, 0);
        check("rst_q", rsp_quotient, 0);
        check("rst_dbz", rsp_dbz, 0);
        check("rst_diva", div_a, 0);

        // Single request 8/4 from requester 0.
        set_req(0, 4'd8, 4'd4);
        req_valid = 4'b0001;
        accept("t1", 4'b0001);
        req_valid = '0;
        check("t1_diva", div_a, 8);
        check("t1_divb", div_b, 4);
        check("t1_busy_ready", req_ready, 0);
        expect_rsp("t1", 4'b0001, 4'd2, 4'd0, 1'b0, DIV_LAT, 2);

        // Requesters 1 and 3 together: 1 first, then 3.
        set_req(1, 4'd8, 4'd3);
        set_req(3, 4'd8, 4'd5);
        req_valid = 4'b1010;
        accept("t2a", 4'b0010);
        expect_rsp("t2a", 4'b0010, 4'd2, 4'd2, 1'b0, DIV_LAT, 2);
        accept("t2b", 4'b1000);
        req_valid = '0;
        expect_rsp("t2b", 4'b1000, 4'd1, 4'd3, 1'b0, DIV_LAT, 2);

        // All four held valid for eight operations: strict rotation.
        for (int i = 0; i < 4; i++) set_req(i, ta[i], tb[i]);
        req_valid = 4'hF;
        for (int n = 0; n < 8; n++) begin
            accept("t3", 4'b0001 << (n % 4));
            if (n == 7) req_valid = '0;
            expect_rsp("t3", 4'b0001 << (n % 4), tq[n % 4], tr[n % 4], 1'b0, DIV_LAT, 2);
        end

        // Divide-by-zero from requester 2.
        set_req(2, 4'd7, 4'd0);
        req_valid = 4'b0100;
        accept("t4", 4'b0100);
        req_valid = '0;
        expect_rsp("t4", 4'b0100, 4'hF, 4'd7, 1'b1, 0, 0);

        // Operands change mid-flight; result uses the accepted pair, dbz clears.
        set_req(0, 4'd10, 4'd3);
        req_valid = 4'b0001;
        accept("t6", 4'b0001);
        req_valid = '0;
        repeat (3) @(negedge clk);
        set_req(0, 4'd1, 4'd5);
        repeat (7) @(negedge clk);
        check("t6_diva", div_a, 10);
        check("t6_divb", div_b, 3);
        expect_rsp("t6", 4'b0001, 4'd3, 4'd1, 1'b0, DIV_LAT - 10, 0);

        // Reset during WAIT of 8/3.
        set_req(0, 4'd8, 4'd3);
        req_valid = 4'b0001;
        accept("t5", 4'b0001);
        req_valid = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_start", div_start, 0);
        check("t5_rspv", rsp_valid, 0);
        check("t5_diva", div_a, 0);
        check("t5_divb", div_b, 0);
        check("t5_q", rsp_quotient, 0);
        check("t5_r", rsp_remainder, 0);
        check("t5_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== '0) quiet++;
        end
        check("t5_no_rsp", quiet, 0);
        // Pointer is back at 0, so requester 0 wins over 1.
        set_req(0, 4'd9, 4'd2);
        set_req(1, 4'd9, 4'd4);
        req_valid = 4'b0011;
        accept("t5b", 4'b0001);
        req_valid = '0;
        expect_rsp("t5b", 4'b0001, 4'd4, 4'd1, 1'b0, DIV_LAT, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
